sparc_rtap_core_req: RTL and testbench

//  Core-side request sequencer between the tile JTAG/rtap controller and the core debug units
//  (IFU shadow-scan snapshot, etc.). It accepts one debug request at a time via valid/ready and

---
 rtl/sparc_rtap_core_req_pkg.sv | 22 ++
 rtl/sparc_rtap_core_req.sv | 105 ++++++++++
 tb/tb_sparc_rtap_core_req.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_rtap_core_req_pkg.sv
// Shared definitions for the core-side rtap request sequencer:
// bus widths, core unit ids and the sequencer FSM state type.
package sparc_rtap_core_req_pkg;

   // Core/JTAG bus geometry shared with the rtap controller
   localparam int unsigned CoreJtagBusWidth = 128;
   localparam int unsigned JtagCoreIdWidth  = 4;

   // Core debug unit ids
   localparam logic [JtagCoreIdWidth-1:0] JtagCoreIdNone     = 4'h0;
   localparam logic [JtagCoreIdWidth-1:0] JtagCoreIdIfuSscan = 4'h1;
   localparam logic [JtagCoreIdWidth-1:0] JtagCoreIdLsuSscan = 4'h2;
   localparam logic [JtagCoreIdWidth-1:0] JtagCoreIdTlu      = 4'h3;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } rtap_state_e;

endpackage

// File: rtl/sparc_rtap_core_req.sv
// Core-side rtap request sequencer. Accepts one debug request at a time, issues a
// single-cycle strobe onto the core bus, samples the OR'd response bus RESP_LAT cycles
// later and holds the result until the consumer takes it.
// Optional feature: define SPARC_RTAP_XACT_CNT_EN to build the saturating
// completed-transaction counter; otherwise xact_cnt is tied to zero.
module sparc_rtap_core_req
   import sparc_rtap_core_req_pkg::*;
#(
   parameter int unsigned DATA_W   = CoreJtagBusWidth,
   parameter int unsigned ID_W     = JtagCoreIdWidth,
   parameter int unsigned RESP_LAT = 1
) (
   input  logic              rclk,
   input  logic              rst_n,
   input  logic              req_val,
   output logic              req_rdy,
   input  logic [ID_W-1:0]   req_id,
   input  logic [1:0]        req_tid,
   input  logic [DATA_W-1:0] req_data,
   output logic              rtap_core_val,
   output logic [ID_W-1:0]   rtap_core_id,
   output logic [1:0]        rtap_core_threadid,
   output logic [DATA_W-1:0] rtap_core_data,
   input  logic [DATA_W-1:0] core_rtap_data,
   output logic              resp_val,
   input  logic              resp_rdy,
   output logic [DATA_W-1:0] resp_data,
   output logic [15:0]       xact_cnt
);

   // Wait counter only needs to hold RESP_LAT-1; keep at least one bit
   localparam int unsigned CntW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

   rtap_state_e     state_q;
   logic [CntW-1:0] wait_cnt_q;

   assign req_rdy = (state_q == StIdle);

   // Sequencer FSM with registered strobe, request fields and response
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= StIdle;
         wait_cnt_q         <= '0;
         rtap_core_val      <= 1'b0;
         rtap_core_id       <= '0;
         rtap_core_threadid <= '0;
         rtap_core_data     <= '0;
         resp_val           <= 1'b0;
         resp_data          <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_val) begin
                  rtap_core_id       <= req_id;
                  rtap_core_threadid <= req_tid;
                  rtap_core_data     <= req_data;
                  rtap_core_val      <= 1'b1;
                  state_q            <= StIssue;
               end
            end
            StIssue: begin
               // Strobe lasts exactly one cycle; id/tid/data stay until next accept
               rtap_core_val <= 1'b0;
               wait_cnt_q    <= CntW'(RESP_LAT - 1);
               state_q       <= StWait;
            end
            StWait: begin
               // Bus is only meaningful in the capture cycle; timing is fixed
               if (wait_cnt_q == '0) begin
                  resp_data <= core_rtap_data;
                  resp_val  <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            StResp: begin
               if (resp_rdy) begin
                  resp_val <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef SPARC_RTAP_XACT_CNT_EN
   logic [15:0] xact_cnt_q;

   // Count response handshakes, saturating at all-ones
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         xact_cnt_q <= '0;
      end else if (resp_val && resp_rdy && (xact_cnt_q != 16'hFFFF)) begin
         xact_cnt_q <= xact_cnt_q + 16'd1;
      end
   end

   assign xact_cnt = xact_cnt_q;
`else
   assign xact_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sparc_rtap_core_req.sv
// Bench for sparc_rtap_core_req: unit 0 runs with RESP_LAT=1, unit 1 with RESP_LAT=3.
// Expected responses are queued when stimulus is driven and compared when resp_val shows.
module tb_sparc_rtap_core_req;
   import sparc_rtap_core_req_pkg::*;

   logic         rclk;
   logic         rst_n;
   logic         req_val            [2];
   logic         req_rdy            [2];
   logic [3:0]   req_id             [2];
   logic [1:0]   req_tid            [2];
   logic [127:0] req_data           [2];
   logic         rtap_core_val      [2];
   logic [3:0]   rtap_core_id       [2];
   logic [1:0]   rtap_core_threadid [2];
   logic [127:0] rtap_core_data     [2];
   logic [127:0] core_rtap_data     [2];
   logic         resp_val           [2];
   logic         resp_rdy           [2];
   logic [127:0] resp_data          [2];
   logic [15:0]  xact_cnt           [2];

   int total = 0;
   int bad   = 0;
   int exp_cnt [2];
   logic [127:0] exp_q0 [$];
   logic [127:0] exp_q1 [$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sparc_rtap_core_req #(
         .DATA_W   (128),
         .ID_W     (4),
         .RESP_LAT ((g == 0) ? 1 : 3)
      ) u_dut (
         .rclk               (rclk),
         .rst_n              (rst_n),
         .req_val            (req_val[g]),
         .req_rdy            (req_rdy[g]),
         .req_id             (req_id[g]),
         .req_tid            (req_tid[g]),
         .req_data           (req_data[g]),
         .rtap_core_val      (rtap_core_val[g]),
         .rtap_core_id       (rtap_core_id[g]),
         .rtap_core_threadid (rtap_core_threadid[g]),
         .rtap_core_data     (rtap_core_data[g]),
         .core_rtap_data     (core_rtap_data[g]),
         .resp_val           (resp_val[g]),
         .resp_rdy           (resp_rdy[g]),
         .resp_data          (resp_data[g]),
         .xact_cnt           (xact_cnt[g])
      );
   end

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   function automatic logic [15:0] want_xcnt(input int u);
`ifdef SPARC_RTAP_XACT_CNT_EN
      return 16'(exp_cnt[u]);
`else
      return 16'h0;
`endif
   endfunction

   // One transaction on unit u; entered and left at #1 after a posedge with the unit idle
   task automatic xact(input int u, input logic [3:0] id, input logic [1:0] tid,
                       input logic [127:0] d, input logic [127:0] rsp, input int stall);
      int lat;
      logic [127:0] want;
      lat = (u == 0) ? 1 : 3;
      total++;
      if (req_rdy[u] !== 1'b1) begin
         bad++; $display("FAIL idle_rdy u%0d got %b want 1", u, req_rdy[u]);
      end
      req_val[u] = 1'b1; req_id[u] = id; req_tid[u] = tid; req_data[u] = d;
      core_rtap_data[u] = 128'h1234;
      if (u == 0) exp_q0.push_back(rsp); else exp_q1.push_back(rsp);
      // T1: strobe cycle
      @(posedge rclk); #1;
      req_val[u] = 1'b0;
      total++;
      if (rtap_core_val[u] !== 1'b1 || rtap_core_id[u] !== id || rtap_core_threadid[u] !== tid
          || rtap_core_data[u] !== d || req_rdy[u] !== 1'b0) begin
         bad++;
         $display("FAIL issue u%0d got val=%b id=%h tid=%h data=%h rdy=%b want val=1 id=%h tid=%h data=%h rdy=0",
                  u, rtap_core_val[u], rtap_core_id[u], rtap_core_threadid[u], rtap_core_data[u],
                  req_rdy[u], id, tid, d);
      end
      core_rtap_data[u] = 128'h1234;
      // T2..T(lat+1): wait cycles, response driven only in the capture cycle
      for (int k = 1; k <= lat; k++) begin
         @(posedge rclk); #1;
         total++;
         if (rtap_core_val[u] !== 1'b0 || resp_val[u] !== 1'b0) begin
            bad++; $display("FAIL wait u%0d k=%0d got val=%b resp_val=%b want 0 0",
                            u, k, rtap_core_val[u], resp_val[u]);
         end
         core_rtap_data[u] = (k == lat) ? rsp : 128'h1234;
      end
      // First response cycle
      @(posedge rclk); #1;
      core_rtap_data[u] = 128'h1234;
      if (u == 0) want = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
      else        want = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
      total++;
      if (resp_val[u] !== 1'b1 || resp_data[u] !== want) begin
         bad++; $display("FAIL resp u%0d got val=%b data=%h want val=1 data=%h",
                         u, resp_val[u], resp_data[u], want);
      end
      if (stall > 0) begin
         resp_rdy[u] = 1'b0;
         req_val[u]  = 1'b1; req_id[u] = 4'hF; req_data[u] = '1;
         for (int s = 0; s < stall; s++) begin
            @(posedge rclk); #1;
            total++;
            if (resp_val[u] !== 1'b1 || resp_data[u] !== want || req_rdy[u] !== 1'b0
                || rtap_core_val[u] !== 1'b0) begin
               bad++;
               $display("FAIL stall u%0d s=%0d got val=%b data=%h rdy=%b strobe=%b want 1 %h 0 0",
                        u, s, resp_val[u], resp_data[u], req_rdy[u], rtap_core_val[u], want);
            end
         end
         resp_rdy[u] = 1'b1;
         req_val[u]  = 1'b0;
      end
      @(posedge rclk); #1;
      if (exp_cnt[u] < 65535) exp_cnt[u]++;
      total++;
      if (resp_val[u] !== 1'b0 || req_rdy[u] !== 1'b1 || rtap_core_val[u] !== 1'b0) begin
         bad++; $display("FAIL handshake u%0d got resp_val=%b rdy=%b strobe=%b want 0 1 0",
                         u, resp_val[u], req_rdy[u], rtap_core_val[u]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         req_val[u] = 1'b0; req_id[u] = '0; req_tid[u] = '0; req_data[u] = '0;
         core_rtap_data[u] = '0; resp_rdy[u] = 1'b1; exp_cnt[u] = 0;
      end
      #23;
      for (int u = 0; u < 2; u++) begin
         total++;
         if (req_rdy[u] !== 1'b1 || rtap_core_val[u] !== 1'b0 || rtap_core_id[u] !== 4'h0
             || rtap_core_threadid[u] !== 2'h0 || rtap_core_data[u] !== 128'h0
             || resp_val[u] !== 1'b0 || resp_data[u] !== 128'h0 || xact_cnt[u] !== 16'h0) begin
            bad++; $display("FAIL reset u%0d got rdy=%b val=%b id=%h resp_val=%b data=%h cnt=%h",
                            u, req_rdy[u], rtap_core_val[u], rtap_core_id[u], resp_val[u],
                            resp_data[u], xact_cnt[u]);
         end
      end
      @(negedge rclk); rst_n = 1'b1;
      @(posedge rclk); #1;
   endtask

   task automatic test_strobe_capture();
      xact(0, JtagCoreIdIfuSscan, 2'd2, 128'hA5A5_0001, 128'hDEAD_BEEF, 0);
   endtask

   task automatic test_backpressure();
      xact(0, JtagCoreIdLsuSscan, 2'd1, 128'h77, 128'hCAFE_F00D_0000_0001, 10);
   endtask

   task automatic test_lat3();
      xact(1, JtagCoreIdTlu, 2'd3, 128'h55, 128'h0123_4567_89AB_CDEF_0F0F, 0);
      xact(1, JtagCoreIdIfuSscan, 2'd0, 128'h66, 128'h0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         xact(0, 4'(i + 4), 2'(i), 128'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0);
      end
   endtask

   task automatic test_reset_in_wait();
      req_val[1] = 1'b1; req_id[1] = 4'h9; req_tid[1] = 2'd1; req_data[1] = 128'h99;
      @(posedge rclk); #1;
      req_val[1] = 1'b0;
      @(posedge rclk); #1;
      core_rtap_data[1] = 128'hBAD;
      #2 rst_n = 1'b0;
      #1;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      total++;
      if (req_rdy[1] !== 1'b1 || rtap_core_val[1] !== 1'b0 || rtap_core_id[1] !== 4'h0
          || rtap_core_threadid[1] !== 2'h0 || rtap_core_data[1] !== 128'h0
          || resp_val[1] !== 1'b0 || resp_data[1] !== 128'h0 || xact_cnt[1] !== 16'h0) begin
         bad++; $display("FAIL rst_wait got rdy=%b val=%b id=%h data=%h resp_val=%b rdata=%h cnt=%h",
                         req_rdy[1], rtap_core_val[1], rtap_core_id[1], rtap_core_data[1],
                         resp_val[1], resp_data[1], xact_cnt[1]);
      end
      @(negedge rclk); @(negedge rclk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge rclk); #1;
         total++;
         if (rtap_core_val[1] !== 1'b0 || resp_val[1] !== 1'b0) begin
            bad++; $display("FAIL no_replay i=%0d got strobe=%b resp_val=%b want 0 0",
                            i, rtap_core_val[1], resp_val[1]);
         end
      end
      xact(1, 4'h2, 2'd2, 128'h1_0000, 128'h5EED, 0);
   endtask

   task automatic test_xact_cnt();
      for (int i = 0; i < 5; i++) begin
         xact(0, JtagCoreIdIfuSscan, 2'(i), 128'(i), 128'(i * 3 + 1), 0);
      end
      total++;
      if (xact_cnt[0] !== want_xcnt(0)) begin
         bad++; $display("FAIL xact_cnt u0 got %0d want %0d", xact_cnt[0], want_xcnt(0));
      end
      total++;
      if (xact_cnt[1] !== want_xcnt(1)) begin
         bad++; $display("FAIL xact_cnt u1 got %0d want %0d", xact_cnt[1], want_xcnt(1));
      end
   endtask

   initial begin
      test_reset();
      test_strobe_capture();
      test_backpressure();
      test_lat3();
      test_back_to_back();
      test_reset_in_wait();
      test_xact_cnt();
      total++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain got %0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
